// File: rtl/puf_tmv_sampler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : puf_tmv_sampler                                              |
// | Description : Temporal-majority-vote front end for a raw 32-bit PUF macro. |
// |               Build option PUF_TMV_STABILITY_EN adds unstable-bit outputs. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module puf_tmv_sampler #(
  parameter  int PUF_BLOCKS = 2,
  parameter  int SAMPLES    = 5,
  localparam int CNT_W      = $clog2(SAMPLES + 1),
  localparam int ADDR_W     = (PUF_BLOCKS > 1) ? $clog2(PUF_BLOCKS) : 1,
  localparam int UCNT_W     = $clog2(PUF_BLOCKS * 32 + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     puf_read_req,
  output logic [PUF_BLOCKS*32-1:0] puf_data,
  output logic                     puf_valid,
  output logic                     busy,
  output logic                     raw_req,
  output logic [ADDR_W-1:0]        raw_addr,
  input  logic [31:0]              raw_data,
  input  logic                     raw_ack
`ifdef PUF_TMV_STABILITY_EN
  ,
  output logic [PUF_BLOCKS*32-1:0] unstable_mask,
  output logic [UCNT_W-1:0]        unstable_count
`endif
);

  localparam int               c_bits     = PUF_BLOCKS * 32;
  localparam logic [CNT_W-1:0] c_thresh   = CNT_W'((SAMPLES + 1) / 2);
  localparam logic [CNT_W-1:0] c_smp_last = CNT_W'(SAMPLES - 1);
  localparam logic [ADDR_W-1:0] c_blk_last = ADDR_W'(PUF_BLOCKS - 1);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_req  = 2'd1;
  localparam logic [1:0] c_st_vote = 2'd2;
  localparam logic [1:0] c_st_done = 2'd3;

  generate
    if ((SAMPLES < 1) || (SAMPLES > 15) || ((SAMPLES % 2) == 0) || (PUF_BLOCKS < 1)) begin : g_bad_params
      $error("puf_tmv_sampler: SAMPLES must be odd in 1..15 and PUF_BLOCKS >= 1");
    end
  endgenerate

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [ADDR_W-1:0] r_blk;
  logic [CNT_W-1:0]  r_smp;
  logic              r_armed;
  logic [CNT_W-1:0]  r_cnt [c_bits];
  logic              w_start;
  logic              w_xfer;
  logic              w_last;

  assign w_start = (r_state == c_st_idle) && puf_read_req && r_armed;
  assign w_xfer  = raw_req && raw_ack;
  assign w_last  = (r_blk == c_blk_last) && (r_smp == c_smp_last);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle: if (w_start) w_state_nxt = c_st_req;
      c_st_req:  if (w_xfer && w_last) w_state_nxt = c_st_vote;
      c_st_vote: w_state_nxt = c_st_done;
      c_st_done: w_state_nxt = c_st_idle;
      default:   w_state_nxt = c_st_idle;
    endcase
  end

  // Outputs decode straight from state so an async reset drops them at once.
  always_comb begin
    raw_req   = (r_state == c_st_req);
    raw_addr  = (r_state == c_st_req) ? r_blk : '0;
    busy      = (r_state != c_st_idle);
    puf_valid = (r_state == c_st_done);
  end

  // Block index runs fastest so reads interleave 0,1,0,1,... across samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_blk   <= '0;
      r_smp   <= '0;
      r_armed <= 1'b1;
    end else if (w_start) begin
      r_blk   <= '0;
      r_smp   <= '0;
      r_armed <= 1'b0;
    end else begin
      if ((r_state == c_st_idle) && !puf_read_req) begin
        r_armed <= 1'b1;
      end
      if (w_xfer) begin
        if (r_blk == c_blk_last) begin
          r_blk <= '0;
          r_smp <= r_smp + CNT_W'(1);
        end else begin
          r_blk <= r_blk + ADDR_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int j = 0; j < c_bits; j++) r_cnt[j] <= '0;
    end else if (w_start) begin
      for (int j = 0; j < c_bits; j++) r_cnt[j] <= '0;
    end else if (w_xfer) begin
      for (int b = 0; b < PUF_BLOCKS; b++) begin
        if (r_blk == ADDR_W'(b)) begin
          for (int i = 0; i < 32; i++) begin
            r_cnt[32*b+i] <= r_cnt[32*b+i] + CNT_W'(raw_data[i]);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      puf_data <= '0;
    end else if (r_state == c_st_vote) begin
      for (int j = 0; j < c_bits; j++) puf_data[j] <= (r_cnt[j] >= c_thresh);
    end
  end

`ifdef PUF_TMV_STABILITY_EN
  logic [c_bits-1:0] w_unstable;
  logic [UCNT_W-1:0] w_unstable_count;

  // A bit is unstable when the samples disagree: neither all-0 nor all-1.
  always_comb begin
    w_unstable       = '0;
    w_unstable_count = '0;
    for (int j = 0; j < c_bits; j++) begin
      w_unstable[j]    = (r_cnt[j] != '0) && (r_cnt[j] != CNT_W'(SAMPLES));
      w_unstable_count = w_unstable_count + UCNT_W'(w_unstable[j]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      unstable_mask  <= '0;
      unstable_count <= '0;
    end else if (r_state == c_st_vote) begin
      unstable_mask  <= w_unstable;
      unstable_count <= w_unstable_count;
    end
  end
`endif

endmodule
`default_nettype wire
